// File: rtl/tmds_encoder_dvi.sv
// DVI 1.0 TMDS 8b/10b encoder for one colour channel.
// Stage 1 minimises transitions; stage 2 balances DC using a running bias.
module tmds_encoder_dvi #(
    parameter int unsigned BIAS_W = 5
) (
    input  logic       clk_pix,
    input  logic       rst_pix_n,
    input  logic       de,
    input  logic [1:0] ctrl,
    input  logic [7:0] data,
    output logic [9:0] tmds
);

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    localparam logic signed [BIAS_W-1:0] ZERO  = '0;
    localparam logic signed [BIAS_W-1:0] TWO   = BIAS_W'(2);
    localparam logic signed [BIAS_W-1:0] EIGHT = BIAS_W'(8);

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

    // Chain each bit against the previous encoded bit; bit 8 records XOR (1) or XNOR (0).
    function automatic logic [8:0] minimise(input logic [7:0] d);
        logic [8:0] q;
        logic [3:0] n1;
        logic       use_xnor;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    // Stage 1 registers
    logic [8:0] qm_q;
    logic       de_q;
    logic [1:0] ctrl_q;

    // Stage 2 state
    logic signed [BIAS_W-1:0] bias_q, bias_d;
    logic [9:0]               tmds_d;

    logic [8:0]               qm_d;
    logic [3:0]               n1q;
    logic signed [BIAS_W-1:0] n1q_ext;
    logic signed [BIAS_W-1:0] diff;
    logic                     qm8;
    logic [7:0]               qm_lo;

    always_comb begin
        qm_d = minimise(data);
    end

    always_comb begin
        tmds_d  = CTRL_00;
        bias_d  = ZERO;
        qm8     = qm_q[8];
        qm_lo   = qm_q[7:0];
        n1q     = popcount8(qm_lo);
        n1q_ext = {{(BIAS_W - 4){1'b0}}, n1q};
        // diff = n1q - n0q = 2*n1q - 8
        diff    = n1q_ext + n1q_ext - EIGHT;

        if (de_q) begin
            if ((bias_q == ZERO) || (diff == ZERO)) begin
                tmds_d = {~qm8, qm8, (qm8 ? qm_lo : ~qm_lo)};
                bias_d = qm8 ? (bias_q + diff) : (bias_q - diff);
            end else if (bias_q[BIAS_W-1] == diff[BIAS_W-1]) begin
                // Both nonzero with the same sign: invert to pull the bias back.
                tmds_d = {1'b1, qm8, ~qm_lo};
                bias_d = bias_q - diff + (qm8 ? TWO : ZERO);
            end else begin
                tmds_d = {1'b0, qm8, qm_lo};
                bias_d = bias_q + diff - (qm8 ? ZERO : TWO);
            end
        end else begin
            bias_d = ZERO;
            unique case (ctrl_q)
                2'b00:   tmds_d = CTRL_00;
                2'b01:   tmds_d = CTRL_01;
                2'b10:   tmds_d = CTRL_10;
                default: tmds_d = CTRL_11;
            endcase
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            qm_q   <= '0;
            de_q   <= 1'b0;
            ctrl_q <= 2'b00;
            tmds   <= CTRL_00;
            bias_q <= ZERO;
        end else begin
            qm_q   <= qm_d;
            de_q   <= de;
            ctrl_q <= ctrl;
            tmds   <= tmds_d;
            bias_q <= bias_d;
        end
    end

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// Self-checking bench for tmds_encoder_dvi: directed cases plus a random soak
// against an integer reference encoder, a reference DVI decoder and disparity bounds.
module tb_tmds_encoder_dvi;

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;

    logic       clk_pix;
    logic       rst_pix_n;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic [9:0] tmds;

    int n_checks;
    int n_pass;

    // Reference model state: the input captured one edge ago, and the running bias.
    logic       pipe_de;
    logic [1:0] pipe_ctrl;
    logic [7:0] pipe_data;
    int         mbias;
    int         disp;

    tmds_encoder_dvi #(.BIAS_W(5)) dut (
        .clk_pix  (clk_pix),
        .rst_pix_n(rst_pix_n),
        .de       (de),
        .ctrl     (ctrl),
        .data     (data),
        .tmds     (tmds)
    );

    initial clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return C00;
            2'b01:   return C01;
            2'b10:   return C10;
            default: return C11;
        endcase
    endfunction

    function automatic logic [7:0] dvi_decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d    = '0;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    // Reference encoder working on integer counts.
    task automatic model_encode(input logic [7:0] d, output logic [9:0] sym);
        int         n1;
        int         n1q;
        int         dq;
        logic       xnor_path;
        logic [7:0] q;
        logic [7:0] qi;
        int         m8;
        n1        = $countones(d);
        xnor_path = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        q         = '0;
        q[0]      = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = xnor_path ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        qi  = ~q;
        m8  = xnor_path ? 0 : 1;
        n1q = $countones(q);
        dq  = n1q - (8 - n1q);
        if (mbias == 0 || dq == 0) begin
            sym   = (m8 == 1) ? {2'b01, q} : {2'b10, qi};
            mbias = mbias + ((m8 == 1) ? dq : -dq);
        end else if ((mbias > 0 && dq > 0) || (mbias < 0 && dq < 0)) begin
            sym   = {1'b1, (m8 == 1), qi};
            mbias = mbias + 2 * m8 - dq;
        end else begin
            sym   = {1'b0, (m8 == 1), q};
            mbias = mbias + dq - 2 * (1 - m8);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] c, input logic [7:0] d);
        logic [9:0] exp_sym;
        logic       was_data;
        logic [7:0] was_byte;
        int         dut_bias;
        rst_pix_n = r;
        de        = e;
        ctrl      = c;
        data      = d;
        @(posedge clk_pix);
        #1;
        was_data = 1'b0;
        was_byte = pipe_data;
        if (!r) begin
            exp_sym   = C00;
            mbias     = 0;
            pipe_de   = 1'b0;
            pipe_ctrl = 2'b00;
            pipe_data = 8'h00;
        end else begin
            if (pipe_de) begin
                model_encode(pipe_data, exp_sym);
                was_data = 1'b1;
            end else begin
                exp_sym = ctrl_sym(pipe_ctrl);
                mbias   = 0;
            end
            pipe_de   = e;
            pipe_ctrl = c;
            pipe_data = d;
        end
        dut_bias = $signed(dut.bias_q);
        check("tmds_model", 32'(tmds), 32'(exp_sym));
        check("bias_model", dut_bias, mbias);
        check("bias_bound", 32'(dut_bias >= -8 && dut_bias <= 8), 32'd1);
        if (was_data) begin
            check("decode", 32'(dvi_decode(tmds)), 32'(was_byte));
            disp = disp + 2 * $countones(tmds) - 10;
            check("disparity", 32'(disp >= -18 && disp <= 18), 32'd1);
        end else begin
            disp = 0;
        end
    endtask

    initial begin
        int data_left;
        int ctrl_left;
        logic       r;
        logic       e;
        n_checks  = 0;
        n_pass    = 0;
        mbias     = 0;
        disp      = 0;
        pipe_de   = 1'b0;
        pipe_ctrl = 2'b00;
        pipe_data = 8'h00;
        rst_pix_n = 1'b0;
        de        = 1'b0;
        ctrl      = 2'b00;
        data      = 8'h00;

        // Reset held with live data on the inputs
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 2'b00, 8'hAB);
            check("rst_sym", 32'(tmds), 32'(C00));
        end
        step(1'b1, 1'b1, 2'b00, 8'hAB);
        check("rst_rel_flush", 32'(tmds), 32'(C00));
        step(1'b1, 1'b1, 2'b00, 8'hAB);
        check("rst_first_data", 32'(dvi_decode(tmds)), 32'h0000_00AB);

        // Control symbols
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 1'b0, 2'(c), 8'($urandom));
        end
        check("ctrl_11", 32'(tmds), 32'(C10));
        step(1'b1, 1'b0, 2'b00, 8'h00);
        check("ctrl_11b", 32'(tmds), 32'(C11));

        // Bias walk with 0x00, then a reset pulse mid-stream
        step(1'b1, 1'b1, 2'b00, 8'h00);
        step(1'b1, 1'b1, 2'b00, 8'h00);
        check("walk_1", 32'(tmds), 32'(10'b0100000000));
        check("walk_1_bias", 32'($signed(dut.bias_q)), -32'sd8);
        step(1'b1, 1'b1, 2'b00, 8'h00);
        check("walk_2", 32'(tmds), 32'(10'b1111111111));
        check("walk_2_bias", 32'($signed(dut.bias_q)), 32'sd2);
        step(1'b1, 1'b1, 2'b00, 8'h00);
        check("walk_3", 32'(tmds), 32'(10'b0100000000));
        check("walk_3_bias", 32'($signed(dut.bias_q)), -32'sd6);
        step(1'b0, 1'b1, 2'b00, 8'h00);
        check("mid_rst", 32'(tmds), 32'(C00));
        step(1'b1, 1'b1, 2'b00, 8'h00);
        check("mid_rst_flush", 32'(tmds), 32'(C00));
        step(1'b1, 1'b1, 2'b00, 8'h00);
        check("mid_rst_data", 32'(tmds), 32'(10'b0100000000));

        // XNOR path, bias restart across a single control cycle
        step(1'b1, 1'b0, 2'b00, 8'h00);
        step(1'b1, 1'b1, 2'b00, 8'hFF);
        step(1'b1, 1'b0, 2'b00, 8'h00);
        check("xnor_ff", 32'(tmds), 32'(10'b1000000000));
        check("xnor_bias", 32'($signed(dut.bias_q)), -32'sd8);
        step(1'b1, 1'b1, 2'b00, 8'hFF);
        check("xnor_gap", 32'(tmds), 32'(C00));
        check("xnor_gap_bias", 32'($signed(dut.bias_q)), 32'sd0);
        step(1'b1, 1'b0, 2'b00, 8'h00);
        check("xnor_ff2", 32'(tmds), 32'(10'b1000000000));

        // Random soak: data bursts 1..32, control bursts 1..8 (~20% control)
        data_left = 0;
        ctrl_left = 0;
        for (int i = 0; i < 20000; i++) begin
            if (data_left == 0 && ctrl_left == 0) begin
                data_left = $urandom_range(1, 32);
                ctrl_left = $urandom_range(1, 8);
            end
            if (data_left > 0) begin
                e = 1'b1;
                data_left--;
            end else begin
                e = 1'b0;
                ctrl_left--;
            end
            r = ($urandom_range(0, 1999) != 0);
            step(r, e, 2'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
